// File: rtl/pr_arb_pkg.sv
// Shared types and defaults for the priority / round-robin arbiter.
package pr_arb_pkg;

  // Default number of requesters; index N-1 has the highest fixed priority.
  localparam int N_DEF = 8;

  // Default maximum consecutive grant cycles in round-robin mode.
  localparam int MAX_HOLD_DEF = 16;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(N_DEF);

  // Arbiter control state.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/pr_rotate_encoder.sv
// Combinational winner search over a request vector.
// Fixed mode: highest set index wins.
// Round-robin mode: search downward from start-1, wrapping from 0 to N-1,
// with start itself checked last. With start=0 both modes give the same order.
module pr_rotate_encoder
  import pr_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic          rr_mode,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  int            base;
  logic [IW-1:0] pos;

  // Walk the candidates in search order and keep the first requesting one.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path through
    // the block leaves a value unassigned, which would infer a latch.
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    base   = rr_mode ? int'(start) : 0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((base + N - k) % N);
      if (!found && req[pos]) begin
        found       = 1'b1;
        idx         = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pr_arbiter.sv
// N-way arbiter with fixed-priority and round-robin modes, registered one-hot
// grant, grant holding while the owner keeps requesting, and a round-robin
// hold timeout that hands the resource to a waiting requester.
module pr_arbiter
  import pr_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic                rr_mode,
  output logic [N-1:0]        grant,
  output logic [idx_w(N)-1:0] grant_idx,
  output logic                grant_valid,
  output logic                preempt
);

  localparam int IW = idx_w(N);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t        state;
  state_t        state_nx;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] last_idx;
  logic          cur_rr;     // mode latched when the current grant was made

  logic [N-1:0]  enc_req;
  logic [N-1:0]  enc_onehot;
  logic [IW-1:0] enc_idx;
  logic          enc_found;

  logic          owner_req;
  logic          timeout;
  logic          take;
  logic          drop;
  logic          preempt_nx;

  // The current owner is masked out of the search, so "found" in GRANT means
  // some other requester is waiting. In IDLE grant is all-zero, so the mask
  // is a no-op there.
  assign enc_req = req & ~grant;

  pr_rotate_encoder #(
    .N  (N),
    .IW (IW)
  ) u_enc (
    .req     (enc_req),
    .start   (last_idx),
    .rr_mode (rr_mode),
    .onehot  (enc_onehot),
    .idx     (enc_idx),
    .found   (enc_found)
  );

  assign owner_req = req[grant_idx];
  assign timeout   = cur_rr && (hold_cnt == HOLD_LAST) && enc_found;

  // State register; reset is synchronous and overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled before the edge.
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: leave GRANT only when the owner stops requesting and
  // nobody else is waiting.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (enc_found) state_nx = ST_GRANT;
      ST_GRANT: if (!owner_req && !enc_found) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Output decode: when to load a new winner, drop to idle, or flag preemption.
  always_comb begin
    take       = 1'b0;
    drop       = 1'b0;
    preempt_nx = 1'b0;
    unique case (state)
      ST_IDLE:  take = enc_found;
      ST_GRANT: begin
        if (!owner_req) begin
          take = enc_found;
          drop = !enc_found;
        end else if (timeout) begin
          take       = 1'b1;
          preempt_nx = 1'b1;
        end
      end
      default:  drop = 1'b1;
    endcase
  end

  // Registered outputs and arbitration bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
      hold_cnt    <= '0;
      last_idx    <= '0;
      cur_rr      <= 1'b0;
    end else if (take) begin
      grant       <= enc_onehot;
      grant_idx   <= enc_idx;
      grant_valid <= 1'b1;
      preempt     <= preempt_nx;
      hold_cnt    <= '0;
      last_idx    <= enc_idx;
      cur_rr      <= rr_mode;
    end else if (drop) begin
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      preempt <= 1'b0;
      if (state == ST_GRANT && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pr_arbiter.md
PR_ARBITER -- requirements
Module: pr_arbiter

Interface
REQ-001 SHALL have parameter N, default 8: number of requesters; index N-1 is highest fixed priority.
REQ-002 SHALL have parameter MAX_HOLD, default 16: maximum consecutive grant cycles in round-robin mode; legal range 2..255.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, N: request vector, bit i = requester i wants the resource.
REQ-006 SHALL have port rr_mode, input, 1: 0 = fixed priority, 1 = round-robin.
REQ-007 SHALL have port grant, output, N: registered one-hot grant, all-zero when none.
REQ-008 SHALL have port grant_idx, output, $clog2(N): index of the granted requester, 0 when grant is all-zero.
REQ-009 SHALL have port grant_valid, output, 1: high iff grant is non-zero.
REQ-010 SHALL have port preempt, output, 1: one-cycle pulse when a grant is withdrawn by timeout.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and GRANT; IDLE drives grant=0.
REQ-012 SHALL in IDLE with req!=0 select a winner and enter GRANT, with the grant visible on the next rising edge (1-cycle latency).
REQ-013 SHALL in fixed mode select the highest set index of req.
REQ-014 SHALL in round-robin mode select the first set index found searching downward from last_idx-1, wrapping from 0 to N-1, with last_idx itself checked last.
REQ-015 SHALL update last_idx to the winner on every new grant.
REQ-016 SHALL hold grant unchanged while req[grant_idx]=1 and no timeout applies; other requests are ignored (no preemption by priority).
REQ-017 SHALL, on a cycle where req[grant_idx]=0, re-arbitrate over the current req with no idle bubble: next cycle grant = new winner, or IDLE if req=0.
REQ-018 SHALL keep hold_cnt, cleared on each new grant and incremented each GRANT cycle, saturating at MAX_HOLD-1.
REQ-019 SHALL, in round-robin mode, when hold_cnt=MAX_HOLD-1 and another request is set, grant the next winner per REQ-014 on the next cycle and pulse preempt in that same cycle.
REQ-020 SHALL, when hold_cnt=MAX_HOLD-1 with no other request set, retain the grant without preempt.
REQ-021 SHALL never time out in fixed mode.
REQ-022 SHALL sample rr_mode only at arbitration points; a change mid-grant takes effect at the next arbitration.
REQ-023 SHALL never assert more than one grant bit, and SHALL never grant a requester whose req bit was 0 at the arbitration edge.

Reset
REQ-024 SHALL on rst=1 at a clock edge force state=IDLE, grant=0, grant_idx=0, grant_valid=0, preempt=0, hold_cnt=0, last_idx=0, overriding all other inputs.
REQ-025 SHALL, with last_idx=0 after reset, make the first round-robin search start at N-1, matching fixed priority.
REQ-026 SHALL, on reset asserted mid-grant, drop the grant on that edge; the first grant after rst deasserts appears one cycle later per REQ-012.

Structure
REQ-027 SHALL place the FSM state enum, default N, default MAX_HOLD, and the index-width localparam in a shared package pr_arb_pkg.
REQ-028 SHALL factor the combinational winner search (req, start index, mode -> one-hot, index, found) into sub-module pr_rotate_encoder.
REQ-029 SHALL register all outputs; no combinational path from req to grant.

Verification
REQ-030 SHALL cover reset: rst=1 with req=8'hFF -> grant=0, grant_valid=0 during reset; first cycle after release -> grant=8'h80, grant_idx=7.
REQ-031 SHALL cover fixed priority: rr_mode=0, req=8'h2C -> grant=8'h20 after 1 cycle; drop req[5] -> next cycle grant=8'h08, with no idle cycle.
REQ-032 SHALL cover round-robin rotation: rr_mode=1, req=8'hFF held, each requester drops its req for one cycle after grant -> grants 7,6,5,...,0,7 in order.
REQ-033 SHALL cover timeout: rr_mode=1, MAX_HOLD=16, req=8'h81 held -> bit 7 granted for 16 cycles, then grant=8'h01 with preempt=1 for exactly one cycle.
REQ-034 SHALL cover the no-contender hold: rr_mode=1, req=8'h10 held 40 cycles -> grant stays 8'h10, preempt never asserts.
REQ-035 SHALL cover mid-grant reset: during grant=8'h04, assert rst for 1 cycle -> grant=0 on that edge; after release with req=8'h06, round-robin grant=8'h04 (search starts at 7).
